// File: rtl/adder_pkg.sv
// Shared defaults and mode encoding for the segmented pipelined adder.
package adder_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_SEG   = 16;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } add_mode_e;

endpackage

// File: rtl/adder_segment.sv
// One SEG-bit slice of the ripple pipeline: registered sum and carry-out, frozen when en=0.
module adder_segment
  import adder_pkg::*;
#(
  parameter int unsigned SEG = DEF_SEG
) (
  input  logic           clk,
  input  logic           en,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout
);

  logic [SEG:0] res_d;
  logic [SEG:0] res_q;

  always_comb begin
    res_d = {1'b0, a} + {1'b0, b} + (SEG+1)'(cin);
  end

  // Data-only register; validity is tracked by the parent pipeline.
  always_ff @(posedge clk) begin
    if (en) begin
      res_q <= res_d;
    end
  end

  assign s    = res_q[SEG-1:0];
  assign cout = res_q[SEG];

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor: one SEG-bit slice per stage, skewed operands, aligned sum.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSEG = WIDTH / SEG;

  add_mode_e        mode_c;
  logic [WIDTH-1:0] b_op_c;
  logic             stall_c;
  logic             en_c;
  logic [NSEG:0]    carry_c;
  logic [WIDTH-1:0] sum_algn_c;
  logic             a_top_c;
  logic             b_top_c;

  logic [NSEG-1:0]  v_d, v_q;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             a_msb_d, a_msb_q;
  logic             b_msb_d, b_msb_q;

  assign mode_c     = add_mode_e'(sub);
  assign b_op_c     = (mode_c == MODE_SUB) ? ~b : b;
  assign carry_c[0] = (mode_c == MODE_SUB) ? 1'b1 : cin;
  assign stall_c    = out_valid_q & ~out_ready;
  assign en_c       = ~stall_c;
  assign in_ready   = ~stall_c;

  for (genvar j = 0; j < NSEG; j++) begin : g_seg
    localparam int unsigned DLY_OUT = NSEG - 1 - j;

    logic [SEG-1:0] a_in_c;
    logic [SEG-1:0] b_in_c;
    logic [SEG-1:0] s_c;

    // Slice j sees its operands j cycles late so the carry from slice j-1 is ready.
    if (j == 0) begin : g_no_skew
      assign a_in_c = a[SEG-1:0];
      assign b_in_c = b_op_c[SEG-1:0];
    end else begin : g_skew
      logic [SEG-1:0] a_dly_d [j];
      logic [SEG-1:0] a_dly_q [j];
      logic [SEG-1:0] b_dly_d [j];
      logic [SEG-1:0] b_dly_q [j];

      always_comb begin
        a_dly_d[0] = a[j*SEG +: SEG];
        b_dly_d[0] = b_op_c[j*SEG +: SEG];
        for (int i = 1; i < j; i++) begin
          a_dly_d[i] = a_dly_q[i-1];
          b_dly_d[i] = b_dly_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (en_c) begin
          a_dly_q <= a_dly_d;
          b_dly_q <= b_dly_d;
        end
      end

      assign a_in_c = a_dly_q[j-1];
      assign b_in_c = b_dly_q[j-1];
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .clk  (clk),
      .en   (en_c),
      .a    (a_in_c),
      .b    (b_in_c),
      .cin  (carry_c[j]),
      .s    (s_c),
      .cout (carry_c[j+1])
    );

    // Early slices wait here until the top slice finishes.
    if (DLY_OUT == 0) begin : g_no_align
      assign sum_algn_c[j*SEG +: SEG] = s_c;
    end else begin : g_align
      logic [SEG-1:0] s_dly_d [DLY_OUT];
      logic [SEG-1:0] s_dly_q [DLY_OUT];

      always_comb begin
        s_dly_d[0] = s_c;
        for (int i = 1; i < int'(DLY_OUT); i++) begin
          s_dly_d[i] = s_dly_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (en_c) begin
          s_dly_q <= s_dly_d;
        end
      end

      assign sum_algn_c[j*SEG +: SEG] = s_dly_q[DLY_OUT-1];
    end

    if (j == NSEG - 1) begin : g_top_sign
      assign a_top_c = a_in_c[SEG-1];
      assign b_top_c = b_in_c[SEG-1];
    end
  end

  always_comb begin
    v_d         = v_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    if (en_c) begin
      v_d         = NSEG'({v_q, in_valid});
      out_valid_d = v_q[NSEG-1];
      a_msb_d     = a_top_c;
      b_msb_d     = b_top_c;
      // Bubbles leave the last delivered result on the outputs.
      if (v_q[NSEG-1]) begin
        sum_d  = sum_algn_c;
        cout_d = carry_c[NSEG];
        ovf_d  = (a_msb_q == b_msb_q) && (sum_algn_c[WIDTH-1] != a_msb_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    a_msb_q <= a_msb_d;
    b_msb_q <= b_msb_d;
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=64, SEG=16): latency, arithmetic, stall, reset, throughput.
module tb_pipelined_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  pipelined_adder #(.WIDTH(64), .SEG(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum}
  function automatic logic [65:0] ref_add(input logic [63:0] ra, input logic [63:0] rb,
                                          input logic rc, input logic rs);
    logic [63:0] bp;
    logic [64:0] r;
    logic        o;
    bp = rs ? ~rb : rb;
    r  = {1'b0, ra} + {1'b0, bp} + 65'(rs ? 1'b1 : rc);
    o  = (ra[63] == bp[63]) && (r[63] != ra[63]);
    return {o, r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single op through an idle pipe: silent for 4 cycles, then exactly one result.
  task automatic issue_one(input string tag, input logic [63:0] ia, input logic [63:0] ib,
                           input logic ic, input logic is, input logic [63:0] es,
                           input logic ec, input logic eo);
    a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_early"}, 64'(out_valid), 64'd0);
      tick();
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    tick();
    chk({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  logic [65:0] exp_q[$];
  logic [65:0] e;

  initial begin
    int got;
    int sent;
    logic [63:0] ops_a [8];
    logic [63:0] ops_b [8];
    logic        ops_c [8];
    logic        ops_s [8];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sum", sum, 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    issue_one("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    issue_one("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    issue_one("sub_pos", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
    issue_one("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    issue_one("cin", 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 1'b1, 1'b0, 64'h31, 1'b0, 1'b0);
    issue_one("seg_carry", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
              64'h0001_0000_0001_0000, 1'b0, 1'b0);

    // Back-pressure: 8 ops, out_ready low in cycles 6..8 of the stream
    for (int i = 0; i < 8; i++) begin
      ops_a[i] = {$urandom, $urandom};
      ops_b[i] = {$urandom, $urandom};
      ops_c[i] = 1'($urandom_range(0, 1));
      ops_s[i] = 1'($urandom_range(0, 1));
    end
    got = 0; sent = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 9);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a = ops_a[sent]; b = ops_b[sent]; cin = ops_c[sent]; sub = ops_s[sent];
      end
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'(!(cyc >= 6 && cyc < 9)));
      if (cyc >= 6 && cyc < 9) begin
        chk("bp_stall_valid", 64'(out_valid), 64'd1);
        if (exp_q.size() > 0) chk("bp_stall_sum", sum, exp_q[0][63:0]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("bp_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("bp_sum", sum, e[63:0]);
          chk("bp_cout", 64'(cout), 64'(e[64]));
          chk("bp_ovf", 64'(ovf), 64'(e[65]));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(ops_a[sent], ops_b[sent], ops_c[sent], ops_s[sent]));
        sent++;
      end
      @(posedge clk); #1;
    end
    chk("bp_count", 64'(got), 64'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    tick();

    // Reset mid-flight: 3 accepted ops, then reset while a 4th is offered
    for (int i = 0; i < 3; i++) begin
      a = 64'(i + 1); b = 64'(100 * (i + 1)); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    rst = 1'b1; a = 64'd999; b = 64'd1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rstmid_out_valid", 64'(out_valid), 64'd0);
    chk("rstmid_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("rstmid_no_stale", 64'(out_valid), 64'd0);
      tick();
    end
    issue_one("post_rst", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
              64'h2222_2222_2222_2211, 1'b0, 1'b0);

    // Throughput: 100 ops back-to-back, results in 100 consecutive cycles from cycle 5
    got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 110; cyc++) begin
      in_valid = (cyc < 100);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      if (cyc < 100) exp_q.push_back(ref_add(a, b, cin, sub));
      #1;
      chk("tp_valid", 64'(out_valid), 64'(cyc >= 5 && cyc < 105));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("tp_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("tp_sum", sum, e[63:0]);
          chk("tp_flags", 64'({cout, ovf}), 64'({e[64], e[65]}));
        end
        got++;
      end
      @(posedge clk); #1;
    end
    chk("tp_count", 64'(got), 64'd100);
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning operand and sum width in bits.
REQ-002 SHALL have parameter SEG, default 16, meaning segment width added per pipeline stage; WIDTH % SEG == 0, NSEG = WIDTH/SEG >= 1.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have ports a, b  input  WIDTH each  unsigned/two's-complement operands.
REQ-008 SHALL have port cin  input  1  carry-in; used in add mode only.
REQ-009 SHALL have port sub  input  1  0 = a+b+cin, 1 = a-b.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port cout  output  1  carry out of MSB (sub mode: 1 = no borrow).
REQ-014 SHALL have port ovf  output  1  signed two's-complement overflow.

Function
REQ-015 SHALL accept a transfer when in_valid && in_ready; SHALL deliver when out_valid && out_ready.
REQ-016 SHALL compute stage k (0..NSEG-1) as segment k of a + b' + carry from stage k-1, where b' = sub ? ~b : b and stage-0 carry-in = sub ? 1 : cin.
REQ-017 SHALL delay upper operand segments by skew registers so segment k is added exactly k cycles after acceptance; sum bits of lower segments SHALL be delayed to align at output.
REQ-018 SHALL have latency NSEG cycles: operands accepted at edge T appear with out_valid=1 after edge T+NSEG when unstalled.
REQ-019 SHALL sustain one accepted operation per cycle when out_ready stays 1.
REQ-020 SHALL define stall = out_valid && !out_ready; in_ready = !stall; when stall, every stage, valid bit and skew register SHALL hold.
REQ-021 SHALL propagate a per-stage valid bit; bubbles advance through the pipe and are not collapsed.
REQ-022 SHALL hold sum, cout, ovf, out_valid stable while stalled.
REQ-023 SHALL compute ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]); cout = carry out of stage NSEG-1.
REQ-024 SHALL, when NSEG = 1, degenerate to a single registered adder with latency 1.
REQ-025 SHALL ignore a, b, cin, sub when in_valid=0 or in_ready=0.

Reset
REQ-026 SHALL, while rst=1 at an edge, clear all stage valid bits so out_valid=0 and in_ready=1 after that edge.
REQ-027 SHALL reset sum, cout, ovf to 0; skew/data registers need not be reset.
REQ-028 SHALL discard in-flight operations on reset mid-operation; no result of pre-reset inputs SHALL appear afterwards.
REQ-029 SHALL ignore in_valid during the reset cycle.

Structure
REQ-030 SHALL place WIDTH/SEG defaults and an add/sub mode enum in shared package adder_pkg.
REQ-031 SHALL use one sub-module adder_segment (SEG-bit registered add with carry in/out and hold enable), instantiated NSEG times via generate.

Verification (WIDTH=64, SEG=16)
REQ-032 Carry ripple: a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 -> sum=0, cout=1, ovf=0, out_valid 4 cycles after accept.
REQ-033 Subtract: a=5, b=7, sub=1 -> sum=FFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; a=7, b=5 -> sum=2, cout=1.
REQ-034 Overflow: a=7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=8000_0000_0000_0000, ovf=1, cout=0.
REQ-035 Back-pressure: stream 8 random ops back-to-back, drop out_ready for 3 cycles mid-stream -> in_ready=0 exactly while stalled, all 8 results in order, match reference model, output stable during stall.
REQ-036 Reset mid-flight: accept 3 ops, assert rst one cycle at cycle 2 -> out_valid=0 next cycle, no stale results ever emitted, next accepted op returns correct sum at latency 4.
REQ-037 Throughput: 100 back-to-back ops with out_ready=1 -> 100 results in 100 consecutive cycles starting 4 cycles after the first accept.
